shift_deserializer: RTL and testbench

Sequential serial-to-parallel converter. It is the receive-side counterpart of the combinational barrel shifter: it assembles a WIDTH-bit word one bit per accepted beat, shifting left (MSB-first) or right (LSB-first). The completed word is presented through a one-entry valid/ready output buffer. It sits between a bit-serial link and byte-wide datapath logic.

---
 rtl/shift_deserializer_pkg.sv | 10 +
 rtl/shift_deserializer_out_skid_reg.sv | 42 ++++
 rtl/shift_deserializer.sv | 124 ++++++++++++
 tb/tb_shift_deserializer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/shift_deserializer_pkg.sv
// Shared types for the serial deserializer and the barrel shifter.
package shift_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  // dir encoding shared with the barrel shifter
  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

endpackage

// File: rtl/shift_deserializer_out_skid_reg.sv
// One-entry valid/ready holding register for the assembled word and its parity flag.
module out_skid_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_perr,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_perr,
  output logic             o_free
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             r_perr;

  // Slot is free when empty or being drained this cycle
  assign o_free  = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_perr  = r_perr;

  // A load wins over a drain so a simultaneous complete+drain keeps valid high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_perr  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_perr  <= i_perr;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/shift_deserializer.sv
// Serial-to-parallel deserializer, MSB-first or LSB-first, with a one-entry
// valid/ready output buffer. Optional even-parity trailer bit: PARITY_CHECK_EN.
module shift_deserializer
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  input  logic             dir,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             parity_err
);

  // r_cnt value while the final beat of a word is being accepted
`ifdef PARITY_CHECK_EN
  localparam int LAST = WIDTH;
`else
  localparam int LAST = WIDTH - 1;
`endif

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dir_q;
  logic             r_perr_h;

  logic             w_acc;
  logic             w_dir_eff;
  logic [WIDTH-1:0] w_shift_nxt;
  logic             w_data_beat;
  logic             w_done;
  logic             w_free;
  logic             w_load;
  logic [WIDTH-1:0] w_word;
  logic             w_perr;
  logic [WIDTH-1:0] w_ld_data;
  logic             w_ld_perr;

  assign bit_ready = (r_state != HOLD);
  assign w_acc     = bit_valid && bit_ready;

  // dir is only honoured on the first bit of a word
  assign w_dir_eff   = (r_state == IDLE) ? dir : r_dir_q;
  assign w_shift_nxt = (w_dir_eff == DIR_LEFT) ? {r_shift[WIDTH-2:0], bit_in}
                                               : {bit_in, r_shift[WIDTH-1:1]};

  assign w_done = w_acc && (r_state == SHIFT) && (r_cnt == CNT_W'(LAST));

`ifdef PARITY_CHECK_EN
  // Trailer beat is counted but not shifted; the word is already in r_shift
  assign w_data_beat = (r_cnt != CNT_W'(WIDTH));
  assign w_word      = r_shift;
  assign w_perr      = (^r_shift) ^ bit_in;
`else
  assign w_data_beat = 1'b1;
  assign w_word      = w_shift_nxt;
  assign w_perr      = 1'b0;
`endif

  // From HOLD the completed word already sits in r_shift
  assign w_load    = w_free && (w_done || (r_state == HOLD));
  assign w_ld_data = (r_state == HOLD) ? r_shift  : w_word;
  assign w_ld_perr = (r_state == HOLD) ? r_perr_h : w_perr;

  // Word assembly FSM: IDLE -> SHIFT -> (IDLE | HOLD -> IDLE)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_cnt    <= '0;
      r_dir_q  <= DIR_RIGHT;
      r_perr_h <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_acc) begin
          r_dir_q <= dir;
          r_shift <= w_shift_nxt;
          r_cnt   <= CNT_W'(1);
          r_state <= SHIFT;
        end
        SHIFT: if (w_acc) begin
          if (w_data_beat) r_shift <= w_shift_nxt;
          if (w_done) begin
            r_perr_h <= w_perr;
            if (w_free) begin
              r_cnt   <= '0;
              r_state <= IDLE;
            end else begin
              r_state <= HOLD;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        HOLD: if (w_free) begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  out_skid_reg #(.WIDTH(WIDTH)) u_out (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_data  (w_ld_data),
    .i_perr  (w_ld_perr),
    .i_ready (out_ready),
    .o_valid (out_valid),
    .o_data  (data_out),
    .o_perr  (parity_err),
    .o_free  (w_free)
  );

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed bench for shift_deserializer (default WIDTH=8). Inputs are driven
// and outputs sampled on the falling edge.
module tb_shift_deserializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_in, bit_valid, bit_ready, dir;
  logic [7:0] data_out;
  logic       out_valid, out_ready, parity_err;

  int errors = 0;
  int checks = 0;
  int stalls = 0;

  always #5 clk = ~clk;

  shift_deserializer dut (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .dir        (dir),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .parity_err (parity_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance
  task automatic send_bit(input logic b, input logic d);
    int n = 0;
    bit_in = b; dir = d; bit_valid = 1'b1;
    while (!bit_ready && n < 50) begin
      @(negedge clk); n++; stalls++;
    end
    if (n >= 50) chk("accept_timeout", 32'd1, 32'd0);
    @(negedge clk);
    bit_valid = 1'b0;
  endtask

  task automatic send_par(input logic p);
`ifdef PARITY_CHECK_EN
    send_bit(p, 1'b0);
`endif
  endtask

  // MSB-first when d=1 (bit 7 sent first), LSB-first when d=0
  task automatic send_word(input logic [7:0] w, input logic d, input logic p);
    for (int i = 0; i < 8; i++) send_bit(d ? w[7-i] : w[i], d);
    send_par(p);
  endtask

  initial begin
    logic [7:0] v;
    rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; dir = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_parity_err", parity_err, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_bit_ready", bit_ready, 1'b1);

    // MSB-first 1,0,1,1,0,0,1,0
    v = 8'hB2;
    for (int i = 0; i < 7; i++) send_bit(v[7-i], 1'b1);
    chk("msb_valid_before_last", out_valid, 1'b0);
    send_bit(v[0], 1'b1);
    send_par(1'b0);
    chk("msb_valid", out_valid, 1'b1);
    chk("msb_data", data_out, 8'hB2);
    @(negedge clk);
    chk("msb_valid_one_cycle", out_valid, 1'b0);

    // Same stream LSB-first
    for (int i = 0; i < 8; i++) send_bit(v[7-i], 1'b0);
    send_par(1'b0);
    chk("lsb_data", data_out, 8'h4D);
    chk("lsb_valid", out_valid, 1'b1);
    @(negedge clk);

    // dir toggled after bit 3 is ignored
    for (int i = 0; i < 8; i++) send_bit(v[7-i], (i >= 3));
    send_par(1'b0);
    chk("dir_toggle_data", data_out, 8'h4D);
    @(negedge clk);

    // Backpressure: second word held until the buffer drains
    out_ready = 1'b0;
    send_word(8'hA5, 1'b1, 1'b0);
    chk("hold_first_valid", out_valid, 1'b1);
    chk("hold_first_data", data_out, 8'hA5);
    send_word(8'h3C, 1'b1, 1'b0);
    chk("hold_bit_ready", bit_ready, 1'b0);
    repeat (3) @(negedge clk);
    chk("hold_data_stable", data_out, 8'hA5);
    chk("hold_bit_ready_stays", bit_ready, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("hold_second_data", data_out, 8'h3C);
    chk("hold_second_valid", out_valid, 1'b1);
    chk("hold_released", bit_ready, 1'b1);
    @(negedge clk);
    chk("hold_drained", out_valid, 1'b0);

    // Back-to-back words, drain pulse on the completion cycle
    out_ready = 1'b0;
    stalls = 0;
    send_word(8'h5A, 1'b1, 1'b0);
    v = 8'h96;
    for (int i = 0; i < 7; i++) send_bit(v[7-i], 1'b1);
`ifdef PARITY_CHECK_EN
    send_bit(v[0], 1'b1);
    out_ready = 1'b1;
    send_bit(1'b0, 1'b0);
`else
    out_ready = 1'b1;
    send_bit(v[0], 1'b1);
`endif
    out_ready = 1'b0;
    chk("b2b_valid", out_valid, 1'b1);
    chk("b2b_data", data_out, 8'h96);
    chk("b2b_no_stall", stalls, 0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("b2b_drained", out_valid, 1'b0);

    // Reset mid-word with a buffered word present
    out_ready = 1'b0;
    send_word(8'h77, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_data", data_out, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("midrst_ready", bit_ready, 1'b1);
    send_word(8'hFF, 1'b1, 1'b0);
    chk("midrst_ff_data", data_out, 8'hFF);
    chk("midrst_ff_valid", out_valid, 1'b1);
    @(negedge clk);

`ifdef PARITY_CHECK_EN
    send_word(8'hB2, 1'b1, 1'b0);
    chk("par_ok_data", data_out, 8'hB2);
    chk("par_ok_err", parity_err, 1'b0);
    @(negedge clk);
    send_word(8'hB2, 1'b1, 1'b1);
    chk("par_bad_data", data_out, 8'hB2);
    chk("par_bad_err", parity_err, 1'b1);
    @(negedge clk);
`else
    // 9th bit (a 1) starts the next word: 1 then seven 0s -> 0x80
    send_word(8'hB2, 1'b1, 1'b0);
    chk("nopar_first", data_out, 8'hB2);
    chk("nopar_err", parity_err, 1'b0);
    send_word(8'h80, 1'b1, 1'b0);
    chk("nopar_ninth_starts_word", data_out, 8'h80);
    chk("nopar_err2", parity_err, 1'b0);
    @(negedge clk);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
